// File: rtl/id_scanner.sv
// id_scanner: streaming tokenizer that flags identifiers ending in a digit run.
// One character is consumed per clock when char_valid is high. A token is a
// maximal run of letters/digits; a "match" is each letter->digit boundary
// inside a token once at least MIN_ALPHA letters have been seen. Digit runs
// longer than MAX_DIGIT, or digits that arrive too early, park the token in
// S_OVF until the next separator.
// Optional build macro: ID_UNDERSCORE_EN -- when defined, '_' counts as a
// letter; otherwise '_' is a separator.
module id_scanner #(
    parameter int MIN_ALPHA = 1,
    parameter int MAX_DIGIT = 15,
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             char_valid,
    output logic             out,
    output logic             match_pulse,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALPHA = 2'd1;
    localparam logic [1:0] S_DIGIT = 2'd2;
    localparam logic [1:0] S_OVF   = 2'd3;

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] MIN_A   = LEN_W'(MIN_ALPHA);
    localparam logic [LEN_W-1:0] MAX_D   = LEN_W'(MAX_DIGIT);

    logic [1:0]       state_reg, state_next;
    logic [LEN_W-1:0] alpha_reg, alpha_next;
    logic [LEN_W-1:0] digit_reg, digit_next;
    logic [LEN_W-1:0] tok_reg, tok_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pulse_reg, pulse_next;
    logic             out_reg;
    logic             is_letter, is_digit;

    // Saturating increment for the LEN_W-wide run counters.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_MAX) ? v : v + LEN_ONE;
    endfunction

    // Character classification; anything not a letter or digit separates tokens.
    always_comb begin
        is_digit  = (char >= 8'h30) && (char <= 8'h39);
`ifdef ID_UNDERSCORE_EN
        is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                    ((char >= 8'h61) && (char <= 8'h7A)) ||
                    (char == 8'h5F);
`else
        is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                    ((char >= 8'h61) && (char <= 8'h7A));
`endif
    end

    // Next-state, run-counter and match bookkeeping for one consumed char.
    always_comb begin
        state_next = state_reg;
        alpha_next = alpha_reg;
        digit_next = digit_reg;
        tok_next   = tok_reg;
        pulse_next = 1'b0;
        cnt_next   = cnt_reg;
        if (char_valid) begin
            if (!is_letter && !is_digit) begin
                // A separator ends whatever token was in progress.
                state_next = S_IDLE;
                alpha_next = '0;
                digit_next = '0;
                tok_next   = '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (is_letter) begin
                            state_next = S_ALPHA;
                            alpha_next = LEN_ONE;
                            digit_next = '0;
                            tok_next   = LEN_ONE;
                        end else begin
                            // A token may not start with a digit.
                            tok_next = '0;
                        end
                    end
                    S_ALPHA: begin
                        tok_next = sat_inc(tok_reg);
                        if (is_letter) begin
                            alpha_next = sat_inc(alpha_reg);
                        end else if (alpha_reg >= MIN_A) begin
                            state_next = S_DIGIT;
                            digit_next = LEN_ONE;
                            pulse_next = 1'b1;
                        end else begin
                            state_next = S_OVF;
                        end
                    end
                    S_DIGIT: begin
                        tok_next = sat_inc(tok_reg);
                        if (is_letter) begin
                            state_next = S_ALPHA;
                            digit_next = '0;
                            alpha_next = sat_inc(alpha_reg);
                        end else if (digit_reg < MAX_D) begin
                            digit_next = digit_reg + LEN_ONE;
                        end else begin
                            state_next = S_OVF;
                        end
                    end
                    default: begin
                        // Overflowed token: only length keeps counting.
                        tok_next = sat_inc(tok_reg);
                    end
                endcase
            end
        end
        if (pulse_next && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // State and output registers; reset discards the char presented that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            alpha_reg <= '0;
            digit_reg <= '0;
            tok_reg   <= '0;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
            out_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            alpha_reg <= alpha_next;
            digit_reg <= digit_next;
            tok_reg   <= tok_next;
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
            out_reg   <= (state_next == S_DIGIT);
        end
    end

    assign out         = out_reg;
    assign match_pulse = pulse_reg;
    assign tok_len     = tok_reg;
    assign match_cnt   = cnt_reg;

endmodule

// File: doc/id_scanner.md
ID_SCANNER -- requirements
Module: id_scanner

Interface
REQ-001 Parameter MIN_ALPHA, default 1: minimum letters in a token before its first digit.
REQ-002 Parameter MAX_DIGIT, default 15: maximum length of one digit run (range 1..2^LEN_W-1).
REQ-003 Parameter LEN_W, default 8: width of tok_len and of the internal run counters.
REQ-004 Parameter CNT_W, default 16: width of match_cnt.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 char  input  8  ASCII character under test.
REQ-008 char_valid  input  1  char is consumed on a rising edge only when high.
REQ-009 out  output  1  registered; high while the scanner is in S_DIGIT (current token is an identifier ending in digits).
REQ-010 match_pulse  output  1  registered; high for one cycle after each ALPHA->DIGIT transition.
REQ-011 tok_len  output  LEN_W  registered; number of characters in the current token.
REQ-012 match_cnt  output  CNT_W  registered; total matches since reset.

Function
REQ-013 Classes: letter = 0x41..0x5A or 0x61..0x7A; digit = 0x30..0x39; everything else = separator.
REQ-014 States: S_IDLE, S_ALPHA, S_DIGIT, S_OVF; alpha_len and digit_len are internal LEN_W counters.
REQ-015 char_valid low: state, counters and outputs hold; match_pulse is 0 that cycle.
REQ-016 S_IDLE: letter -> S_ALPHA, alpha_len=1, tok_len=1; digit or separator -> S_IDLE, tok_len=0.
REQ-017 S_ALPHA: letter -> S_ALPHA, alpha_len+1; digit with alpha_len>=MIN_ALPHA -> S_DIGIT, digit_len=1, match_pulse=1; digit with alpha_len<MIN_ALPHA -> S_OVF; separator -> S_IDLE.
REQ-018 S_DIGIT: letter -> S_ALPHA, digit_len=0, alpha_len+1; digit with digit_len<MAX_DIGIT -> S_DIGIT, digit_len+1; digit with digit_len==MAX_DIGIT -> S_OVF; separator -> S_IDLE.
REQ-019 S_OVF: letter or digit -> S_OVF; separator -> S_IDLE; out stays 0 until a new token starts.
REQ-020 tok_len increments on every letter/digit consumed outside S_IDLE and clears to 0 on any transition to S_IDLE; alpha_len, tok_len saturate at 2^LEN_W-1, never wrap.
REQ-021 match_cnt increments by 1 on each match_pulse and saturates at 2^CNT_W-1.
REQ-022 Latency: outputs reflect a consumed char on the edge that consumes it (one cycle after char is presented).
REQ-023 Repeated ALPHA->DIGIT within one token (e.g. "a1b2") counts a match each time.

Reset
REQ-024 reset high at a rising edge: state=S_IDLE, all counters 0, out=0, match_pulse=0, tok_len=0, match_cnt=0, regardless of char_valid.
REQ-025 Reset asserted mid-token aborts it; the char presented in that cycle is discarded.

Configuration
REQ-026 Macro ID_UNDERSCORE_EN defined: '_' (0x5F) is classified as letter in every state.
REQ-027 Macro ID_UNDERSCORE_EN undefined: '_' is a separator.

Verification
REQ-028 Reset, then "ab12" valid every cycle -> out 0,0,1,1; match_pulse on 3rd char only; tok_len 1,2,3,4; match_cnt=1.
REQ-029 MIN_ALPHA=2, stream "a1 " -> S_OVF after '1', out never 1, match_cnt=0; space returns S_IDLE, tok_len=0.
REQ-030 MAX_DIGIT=3, stream "x1234" -> out high after '1','2','3', low after '4' (S_OVF); match_cnt=1.
REQ-031 Stream "a1b2" with char_valid low for 3 cycles between 'b' and '2' -> outputs frozen during gap; final match_cnt=2, tok_len=4.
REQ-032 Stream "ab1", reset asserted with '2' -> next cycle out=0, tok_len=0, match_cnt=0; '2' ignored.
REQ-033 Stream "_a9" -> with ID_UNDERSCORE_EN out=1, tok_len=3; without it out=1, tok_len=2 ('_' is a separator).
